// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
//
// Memory-mapped bank of NUM_CH independent reload timers. Each channel has a
// prescaler, an up-counter that reloads from TH on overflow, a sticky status
// bit (ST), an interrupt enable and a one-shot mode. Pending-and-enabled
// status bits are registered onto irq_vec and OR-reduced onto irqout.
//
// Register map (byte addresses, bits [1:0] of addr ignored):
//   BASE_ADDR + 16*c + 0x0 : TH   reload value
//   BASE_ADDR + 16*c + 0x4 : TL   counter
//   BASE_ADDR + 16*c + 0x8 : TCON [0] EN, [1] IE, [2] ST (W1C), [3] OS
//   BASE_ADDR + 16*c + 0xC : PRE  prescale divisor
//   BASE_ADDR + 16*NUM_CH  : IRQ_PEND, read-only, bit c = ST of channel c
//
// Ports:
//   clk     in   system clock, all state changes on rising edge
//   reset   in   asynchronous, active-low; 0 clears all state immediately
//   rd      in   read strobe (rdata is 0 unless rd=1 and the address hits)
//   wr      in   write strobe, sampled on the rising clock edge
//   addr    in   32-bit byte address
//   wdata   in   32-bit write data
//   rdata   out  32-bit combinational read data
//   irqout  out  registered OR of all pending & enabled channel interrupts
//   irq_vec out  registered per-channel pending & enabled
// -----------------------------------------------------------------------------
module timer_bank #(
   parameter int          NUM_CH    = 4,
   parameter int          TIMER_W   = 32,
   parameter int          PRE_W     = 16,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd,
   input  logic              wr,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              irqout,
   output logic [NUM_CH-1:0] irq_vec
);

   localparam int          CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [27:0] NUM_CH_L = 28'(NUM_CH);
   localparam logic [29:0] PEND_IDX = 30'(4 * NUM_CH);

   // ---------------------------------------------------------------------------
   // Address decode. Subtracting the base makes an address below the window
   // wrap to a huge offset, so the single range compare rejects it as well.
   // ---------------------------------------------------------------------------
   logic [31:0]     offset;
   logic            ch_hit;
   logic            pend_hit;
   logic [CH_W-1:0] ch_sel;
   logic [1:0]      reg_sel;

   assign offset   = addr - BASE_ADDR;
   assign ch_hit   = (offset[31:4] < NUM_CH_L);
   assign pend_hit = (offset[31:2] == PEND_IDX);
   assign ch_sel   = offset[4 +: CH_W];
   assign reg_sel  = offset[3:2];

   // Byte-lane bits carry no meaning on this bus.
   logic unused_addr_bits;
   assign unused_addr_bits = ^offset[1:0];

   // Per-channel read words and status, gathered for the read mux and IRQs.
   logic [NUM_CH-1:0][31:0] ch_rdata;
   logic [NUM_CH-1:0]       st_vec;
   logic [NUM_CH-1:0]       ie_vec;

   // ---------------------------------------------------------------------------
   // Channels
   // ---------------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [TIMER_W-1:0] th_q, th_d;
      logic [TIMER_W-1:0] tl_q, tl_d;
      logic [PRE_W-1:0]   pre_q, pre_d;
      logic [PRE_W-1:0]   pcnt_q, pcnt_d;
      logic               en_q, en_d;
      logic               ie_q, ie_d;
      logic               st_q, st_d;
      logic               os_q, os_d;
      logic               sel;
      logic               tick;
      logic               ovf;
      logic [31:0]        word;

      assign sel  = wr & ch_hit & (ch_sel == CH_W'(gi));
      assign tick = en_q & (pcnt_q == pre_q);
      assign ovf  = tick & (&tl_q);

      // Priority order matters: hardware update first, then a software write
      // overrides it, then an overflow forces ST so that set beats W1C.
      always_comb begin
         th_d   = th_q;
         tl_d   = tl_q;
         pre_d  = pre_q;
         en_d   = en_q;
         ie_d   = ie_q;
         st_d   = st_q;
         os_d   = os_q;
         pcnt_d = (en_q && !tick) ? pcnt_q + PRE_W'(1) : '0;

         // Reload uses the pre-edge TH even if TH is written this cycle.
         if (tick) begin
            tl_d = ovf ? th_q : tl_q + TIMER_W'(1);
         end
         if (ovf && os_q) begin
            en_d = 1'b0;
         end

         if (sel) begin
            case (reg_sel)
               2'd0: th_d = wdata[TIMER_W-1:0];
               2'd1: begin
                  tl_d   = wdata[TIMER_W-1:0];
                  pcnt_d = '0;
               end
               2'd2: begin
                  en_d = wdata[0];
                  ie_d = wdata[1];
                  os_d = wdata[3];
                  if (wdata[2]) begin
                     st_d = 1'b0;
                  end
               end
               default: begin
                  pre_d  = wdata[PRE_W-1:0];
                  pcnt_d = '0;
               end
            endcase
         end

         if (ovf) begin
            st_d = 1'b1;
         end
         // A disabled channel always restarts its prescaler from zero.
         if (!en_d) begin
            pcnt_d = '0;
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            pre_q  <= '0;
            pcnt_q <= '0;
            en_q   <= 1'b0;
            ie_q   <= 1'b0;
            st_q   <= 1'b0;
            os_q   <= 1'b0;
         end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            pre_q  <= pre_d;
            pcnt_q <= pcnt_d;
            en_q   <= en_d;
            ie_q   <= ie_d;
            st_q   <= st_d;
            os_q   <= os_d;
         end
      end

      // Zero-extended read word for the addressed register of this channel.
      always_comb begin
         word = '0;
         case (reg_sel)
            2'd0:    word[TIMER_W-1:0] = th_q;
            2'd1:    word[TIMER_W-1:0] = tl_q;
            2'd2:    word[3:0]         = {os_q, st_q, ie_q, en_q};
            default: word[PRE_W-1:0]   = pre_q;
         endcase
      end

      assign ch_rdata[gi] = word;
      assign st_vec[gi]   = st_q;
      assign ie_vec[gi]   = ie_q;
   end

   // ---------------------------------------------------------------------------
   // Read mux
   // ---------------------------------------------------------------------------
   always_comb begin
      rdata = '0;
      if (rd) begin
         if (ch_hit) begin
            rdata = ch_rdata[ch_sel];
         end else if (pend_hit) begin
            rdata[NUM_CH-1:0] = st_vec;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Interrupt outputs, registered one cycle behind ST.
   // ---------------------------------------------------------------------------
   logic [NUM_CH-1:0] irq_vec_q, irq_vec_d;
   logic              irqout_q, irqout_d;

   always_comb begin
      irq_vec_d = st_vec & ie_vec;
      irqout_d  = |(st_vec & ie_vec);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_vec_q <= '0;
         irqout_q  <= 1'b0;
      end else begin
         irq_vec_q <= irq_vec_d;
         irqout_q  <= irqout_d;
      end
   end

   assign irq_vec = irq_vec_q;
   assign irqout  = irqout_q;

endmodule

// File: tb/tb_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_timer_bank
//
// Bench for timer_bank. Instance dut uses the default 4-channel, 32-bit
// configuration and is tracked by a behavioural model; instance dut8 uses
// 8 channels with 16-bit counters for the multi-channel / width scenario.
// -----------------------------------------------------------------------------
module tb_timer_bank;

   localparam logic [31:0] BASE  = 32'h4000_0000;
   localparam logic [31:0] PEND4 = 32'h4000_0040;
   localparam logic [31:0] PEND8 = 32'h4000_0080;
   localparam logic [31:0] UNMAP = 32'h4000_0FF0;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd, wr;
   logic [31:0] addr, wdata, rdata;
   logic        irqout;
   logic [3:0]  irq_vec;
   logic        rd8, wr8;
   logic [31:0] addr8, wdata8, rdata8;
   logic        irqout8;
   logic [7:0]  irq_vec8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   timer_bank dut (
      .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata), .irqout(irqout), .irq_vec(irq_vec)
   );

   timer_bank #(.NUM_CH(8), .TIMER_W(16), .PRE_W(16), .BASE_ADDR(32'h4000_0000)) dut8 (
      .clk(clk), .reset(reset), .rd(rd8), .wr(wr8), .addr(addr8), .wdata(wdata8),
      .rdata(rdata8), .irqout(irqout8), .irq_vec(irq_vec8)
   );

   // ---------------------------------------------------------------------------
   // Behavioural model of the 4-channel instance. The prescaler is modelled as
   // the number of enabled cycles since the last restart; a tick happens when
   // that count is congruent to PRE modulo PRE+1.
   // ---------------------------------------------------------------------------
   logic [31:0] m_th [4];
   logic [31:0] m_tl [4];
   logic [15:0] m_pre [4];
   int unsigned m_age [4];
   bit          m_en [4];
   bit          m_ie [4];
   bit          m_st [4];
   bit          m_os [4];
   logic [3:0]  m_irqv;
   logic        m_irq;

   task automatic model_reset();
      for (int c = 0; c < 4; c++) begin
         m_th[c] = '0; m_tl[c] = '0; m_pre[c] = '0; m_age[c] = 0;
         m_en[c] = 0; m_ie[c] = 0; m_st[c] = 0; m_os[c] = 0;
      end
      m_irqv = '0;
      m_irq  = 1'b0;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] off;
      logic [31:0] v;
      int          c;
      off = a - BASE;
      v   = '0;
      if (off < 32'd64) begin
         c = int'(off[5:4]);
         case (off[3:2])
            2'd0: v = m_th[c];
            2'd1: v = m_tl[c];
            2'd2: v = {28'd0, m_os[c], m_st[c], m_ie[c], m_en[c]};
            default: v = {16'd0, m_pre[c]};
         endcase
      end else if (off[31:2] == 30'd16) begin
         for (int k = 0; k < 4; k++) v[k] = m_st[k];
      end
      return v;
   endfunction

   // Advance the model by one clock using the bus inputs currently driven,
   // then wait for that edge and settle.
   task automatic cycle();
      logic [31:0] n_th [4];
      logic [31:0] n_tl [4];
      logic [15:0] n_pre [4];
      int unsigned n_age [4];
      bit          n_en [4];
      bit          n_ie [4];
      bit          n_st [4];
      bit          n_os [4];
      logic [3:0]  n_irqv;
      logic [31:0] off;
      n_th = m_th; n_tl = m_tl; n_pre = m_pre; n_age = m_age;
      n_en = m_en; n_ie = m_ie; n_st = m_st; n_os = m_os;
      off = addr - BASE;
      for (int c = 0; c < 4; c++) begin
         int unsigned p;
         bit          tick;
         bit          ovf;
         p    = m_pre[c];
         tick = m_en[c] && ((m_age[c] % (p + 1)) == p);
         ovf  = tick && (m_tl[c] == 32'hFFFF_FFFF);
         if (tick) n_tl[c] = ovf ? m_th[c] : m_tl[c] + 32'd1;
         if (ovf && m_os[c]) n_en[c] = 0;
         n_age[c] = m_en[c] ? m_age[c] + 1 : 0;
         if (wr && off < 32'd64 && off[5:4] == 2'(c)) begin
            case (off[3:2])
               2'd0: n_th[c] = wdata;
               2'd1: begin n_tl[c] = wdata; n_age[c] = 0; end
               2'd2: begin
                  n_en[c] = wdata[0]; n_ie[c] = wdata[1]; n_os[c] = wdata[3];
                  if (wdata[2]) n_st[c] = 0;
               end
               default: begin n_pre[c] = wdata[15:0]; n_age[c] = 0; end
            endcase
         end
         if (ovf) n_st[c] = 1;
         if (!n_en[c]) n_age[c] = 0;
         n_irqv[c] = m_st[c] & m_ie[c];
      end
      @(posedge clk);
      #1;
      m_th = n_th; m_tl = n_tl; m_pre = n_pre; m_age = n_age;
      m_en = n_en; m_ie = n_ie; m_st = n_st; m_os = n_os;
      m_irqv = n_irqv;
      m_irq  = |n_irqv;
   endtask

   // ---------------------------------------------------------------------------
   // Bus access
   // ---------------------------------------------------------------------------
   function automatic logic [31:0] ra(input int c, input int r);
      return BASE + 32'(16 * c + 4 * r);
   endfunction

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      wr = 1'b1; addr = a; wdata = d;
      cycle();
      wr = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      rd = 1'b1; addr = a;
      #1;
      d  = rdata;
      rd = 1'b0;
   endtask

   task automatic write8(input logic [31:0] a, input logic [31:0] d);
      wr8 = 1'b1; addr8 = a; wdata8 = d;
      cycle();
      wr8 = 1'b0;
   endtask

   task automatic read8(input logic [31:0] a, output logic [31:0] d);
      rd8 = 1'b1; addr8 = a;
      #1;
      d   = rdata8;
      rd8 = 1'b0;
   endtask

   // Stop all channels and clear their status; the second pass clears an ST
   // that an overflow may have set on the edge of the first pass.
   task automatic quiesce();
      repeat (2) for (int c = 0; c < 4; c++) bus_write(ra(c, 2), 32'h4);
      idle(2);
   endtask

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      logic [31:0] got;
      bus_write(ra(0, 1), 32'hFFFF_FFF0);
      bus_write(ra(0, 2), 32'h3);
      bus_write(ra(1, 2), 32'h1);
      idle(3);
      #2 reset = 1'b0;
      #1;
      bus_read(ra(0, 1), got);
      checks++; if (got !== 32'h0) begin errors++; $display("FAIL reset_async_tl got=%h exp=%h", got, 32'h0); end
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
      idle(3);
      for (int k = 0; k < 18; k++) begin
         logic [31:0] a;
         a = (k < 16) ? ra(k / 4, k % 4) : ((k == 16) ? PEND4 : UNMAP);
         bus_read(a, got);
         checks++; if (got !== 32'h0) begin errors++; $display("FAIL reset_reg addr=%h got=%h exp=%h", a, got, 32'h0); end
      end
      checks++; if (irqout !== 1'b0 || irq_vec !== 4'h0) begin errors++; $display("FAIL reset_irq got=%b/%h exp=0/0", irqout, irq_vec); end
      checks++; if (irqout8 !== 1'b0 || irq_vec8 !== 8'h0) begin errors++; $display("FAIL reset_irq8 got=%b/%h exp=0/0", irqout8, irq_vec8); end
      bus_write(ra(0, 0), 32'h0000_1234);
      bus_write(UNMAP, 32'hFFFF_FFFF);
      bus_write(PEND4, 32'hFFFF_FFFF);
      bus_read(ra(0, 0), got);
      checks++; if (got !== 32'h0000_1234) begin errors++; $display("FAIL unmapped_th0 got=%h exp=%h", got, 32'h0000_1234); end
      for (int k = 0; k < 17; k++) begin
         logic [31:0] a;
         a = (k < 16) ? ra(k / 4, k % 4) : PEND4;
         bus_read(a, got);
         checks++; if (got !== model_read(a)) begin errors++; $display("FAIL unmapped_wr addr=%h got=%h exp=%h", a, got, model_read(a)); end
      end
   endtask

   task automatic test_periodic();
      logic [31:0] got;
      quiesce();
      bus_write(ra(0, 0), 32'hFFFF_FFFC);
      bus_write(ra(0, 1), 32'hFFFF_FFFC);
      bus_write(ra(0, 3), 32'h0);
      bus_write(ra(0, 2), 32'h3);
      idle(3);
      bus_read(ra(0, 1), got);
      checks++; if (got !== 32'hFFFF_FFFF) begin errors++; $display("FAIL periodic_tl3 got=%h exp=%h", got, 32'hFFFF_FFFF); end
      bus_read(ra(0, 2), got);
      checks++; if (got !== 32'h3) begin errors++; $display("FAIL periodic_tcon3 got=%h exp=%h", got, 32'h3); end
      idle(1);
      bus_read(ra(0, 2), got);
      checks++; if (got !== 32'h7) begin errors++; $display("FAIL periodic_st got=%h exp=%h", got, 32'h7); end
      bus_read(ra(0, 1), got);
      checks++; if (got !== 32'hFFFF_FFFC) begin errors++; $display("FAIL periodic_reload got=%h exp=%h", got, 32'hFFFF_FFFC); end
      checks++; if (irqout !== 1'b0) begin errors++; $display("FAIL periodic_irq_lag got=%b exp=0", irqout); end
      idle(1);
      checks++; if (irqout !== 1'b1 || irq_vec !== 4'h1) begin errors++; $display("FAIL periodic_irq got=%b/%h exp=1/1", irqout, irq_vec); end
      bus_write(ra(0, 2), 32'h7);
      bus_read(ra(0, 2), got);
      checks++; if (got !== 32'h3) begin errors++; $display("FAIL periodic_w1c got=%h exp=%h", got, 32'h3); end
      checks++; if (irqout !== 1'b1) begin errors++; $display("FAIL periodic_irq_hold got=%b exp=1", irqout); end
      idle(1);
      checks++; if (irqout !== 1'b0) begin errors++; $display("FAIL periodic_irq_drop got=%b exp=0", irqout); end
      idle(1);
      bus_read(ra(0, 2), got);
      checks++; if (got !== 32'h7) begin errors++; $display("FAIL periodic_repeat got=%h exp=%h", got, 32'h7); end
      bus_read(ra(0, 1), got);
      checks++; if (got !== 32'hFFFF_FFFC) begin errors++; $display("FAIL periodic_repeat_tl got=%h exp=%h", got, 32'hFFFF_FFFC); end
   endtask

   task automatic test_prescaler();
      logic [31:0] got;
      quiesce();
      bus_write(ra(1, 3), 32'h2);
      bus_write(ra(1, 0), 32'hFFFF_FFFE);
      bus_write(ra(1, 1), 32'hFFFF_FFFE);
      bus_write(ra(1, 2), 32'h1);
      idle(2);
      bus_read(ra(1, 1), got);
      checks++; if (got !== 32'hFFFF_FFFE) begin errors++; $display("FAIL pre_tl2 got=%h exp=%h", got, 32'hFFFF_FFFE); end
      idle(1);
      bus_read(ra(1, 1), got);
      checks++; if (got !== 32'hFFFF_FFFF) begin errors++; $display("FAIL pre_tl3 got=%h exp=%h", got, 32'hFFFF_FFFF); end
      idle(2);
      bus_read(ra(1, 2), got);
      checks++; if (got !== 32'h1) begin errors++; $display("FAIL pre_tcon5 got=%h exp=%h", got, 32'h1); end
      idle(1);
      bus_read(ra(1, 2), got);
      checks++; if (got !== 32'h5) begin errors++; $display("FAIL pre_tcon6 got=%h exp=%h", got, 32'h5); end
      bus_read(ra(1, 1), got);
      checks++; if (got !== 32'hFFFF_FFFE) begin errors++; $display("FAIL pre_reload got=%h exp=%h", got, 32'hFFFF_FFFE); end
      idle(2);
      checks++; if (irqout !== 1'b0 || irq_vec !== 4'h0) begin errors++; $display("FAIL pre_no_irq got=%b/%h exp=0/0", irqout, irq_vec); end
   endtask

   task automatic test_oneshot();
      logic [31:0] got;
      quiesce();
      bus_write(ra(2, 0), 32'h0000_0100);
      bus_write(ra(2, 3), 32'h0);
      bus_write(ra(2, 1), 32'hFFFF_FFFF);
      bus_write(ra(2, 2), 32'hB);
      idle(1);
      bus_read(ra(2, 2), got);
      checks++; if (got !== 32'hE) begin errors++; $display("FAIL oneshot_tcon got=%h exp=%h", got, 32'hE); end
      bus_read(PEND4, got);
      checks++; if (got !== 32'h4) begin errors++; $display("FAIL oneshot_pend got=%h exp=%h", got, 32'h4); end
      idle(5);
      bus_read(ra(2, 1), got);
      checks++; if (got !== 32'h0000_0100) begin errors++; $display("FAIL oneshot_hold got=%h exp=%h", got, 32'h100); end
      checks++; if (irqout !== 1'b1 || irq_vec !== 4'h4) begin errors++; $display("FAIL oneshot_irq got=%b/%h exp=1/4", irqout, irq_vec); end
   endtask

   task automatic test_collision();
      logic [31:0] got;
      quiesce();
      bus_write(ra(3, 0), 32'h10);
      bus_write(ra(3, 3), 32'h0);
      bus_write(ra(3, 1), 32'hFFFF_FFFD);
      bus_write(ra(3, 2), 32'h1);
      idle(2);
      bus_write(ra(3, 1), 32'hFFFF_FFFE);          // lands on overflow edge
      bus_read(ra(3, 1), got);
      checks++; if (got !== 32'hFFFF_FFFE) begin errors++; $display("FAIL coll_tl_wr got=%h exp=%h", got, 32'hFFFF_FFFE); end
      bus_read(ra(3, 2), got);
      checks++; if (got !== 32'h5) begin errors++; $display("FAIL coll_tl_st got=%h exp=%h", got, 32'h5); end
      idle(1);
      bus_write(ra(3, 2), 32'h5);                  // W1C on overflow edge
      bus_read(ra(3, 2), got);
      checks++; if (got !== 32'h5) begin errors++; $display("FAIL coll_w1c got=%h exp=%h", got, 32'h5); end
      bus_read(ra(3, 1), got);
      checks++; if (got !== 32'h10) begin errors++; $display("FAIL coll_w1c_tl got=%h exp=%h", got, 32'h10); end
      bus_write(ra(3, 1), 32'hFFFF_FFFF);
      bus_write(ra(3, 0), 32'h20);                 // TH write on overflow edge
      bus_read(ra(3, 1), got);
      checks++; if (got !== 32'h10) begin errors++; $display("FAIL coll_th_old got=%h exp=%h", got, 32'h10); end
      bus_read(ra(3, 0), got);
      checks++; if (got !== 32'h20) begin errors++; $display("FAIL coll_th_new got=%h exp=%h", got, 32'h20); end
      bus_write(ra(3, 2), 32'h9);
      bus_write(ra(3, 1), 32'hFFFF_FFFF);
      bus_write(ra(3, 2), 32'h1);                  // EN=1 vs one-shot clear
      bus_read(ra(3, 2), got);
      checks++; if (got !== 32'h5) begin errors++; $display("FAIL coll_en got=%h exp=%h", got, 32'h5); end
      bus_read(ra(3, 1), got);
      checks++; if (got !== 32'h20) begin errors++; $display("FAIL coll_en_tl got=%h exp=%h", got, 32'h20); end
      idle(1);
      bus_read(ra(3, 1), got);
      checks++; if (got !== 32'h21) begin errors++; $display("FAIL coll_running got=%h exp=%h", got, 32'h21); end
   endtask

   task automatic test_random();
      logic [31:0] got, a, d;
      quiesce();
      for (int c = 0; c < 4; c++) begin
         bus_write(ra(c, 3), 32'($urandom_range(0, 3)));
         bus_write(ra(c, 0), 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
         bus_write(ra(c, 1), 32'hFFFF_FFF8 | 32'($urandom_range(0, 7)));
         bus_write(ra(c, 2), 32'($urandom_range(0, 15)) | 32'h1);
      end
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            int k;
            k = int'($urandom_range(0, 17));
            if (k < 16) begin
               a = ra(k / 4, k % 4);
               case (k % 4)
                  0, 1: d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                  2:    d = 32'($urandom_range(0, 15));
                  default: d = 32'($urandom_range(0, 3));
               endcase
            end else begin
               a = (k == 16) ? PEND4 : UNMAP;
               d = $urandom;
            end
            bus_write(a, d);
         end else begin
            idle(1);
         end
         begin
            int k;
            k = int'($urandom_range(0, 17));
            a = (k < 16) ? ra(k / 4, k % 4) : ((k == 16) ? PEND4 : UNMAP);
         end
         bus_read(a, got);
         checks++; if (got !== model_read(a)) begin errors++; $display("FAIL random_read i=%0d addr=%h got=%h exp=%h", i, a, got, model_read(a)); end
         checks++; if (irqout !== m_irq || irq_vec !== m_irqv) begin errors++; $display("FAIL random_irq i=%0d got=%b/%h exp=%b/%h", i, irqout, irq_vec, m_irq, m_irqv); end
      end
   endtask

   task automatic test_multi();
      logic [31:0] got;
      quiesce();
      write8(BASE + 32'h00, 32'hABCD_FFF0);
      write8(BASE + 32'h50, 32'h1234_FFF0);
      write8(BASE + 32'h04, 32'h5555_FFFD);
      write8(BASE + 32'h54, 32'h5555_FFFE);
      read8(BASE + 32'h04, got);
      checks++; if (got !== 32'h0000_FFFD) begin errors++; $display("FAIL multi_tl_width got=%h exp=%h", got, 32'h0000_FFFD); end
      write8(BASE + 32'h08, 32'h3);
      write8(BASE + 32'h58, 32'h3);
      idle(1);
      read8(PEND8, got);
      checks++; if (got !== 32'h0) begin errors++; $display("FAIL multi_pend_pre got=%h exp=%h", got, 32'h0); end
      idle(1);
      read8(PEND8, got);
      checks++; if (got !== 32'h21) begin errors++; $display("FAIL multi_pend got=%h exp=%h", got, 32'h21); end
      checks++; if (irq_vec8 !== 8'h00) begin errors++; $display("FAIL multi_vec_lag got=%h exp=%h", irq_vec8, 8'h00); end
      read8(BASE + 32'h04, got);
      checks++; if (got !== 32'h0000_FFF0) begin errors++; $display("FAIL multi_reload0 got=%h exp=%h", got, 32'h0000_FFF0); end
      read8(BASE + 32'h50, got);
      checks++; if (got !== 32'h0000_FFF0) begin errors++; $display("FAIL multi_th5 got=%h exp=%h", got, 32'h0000_FFF0); end
      idle(1);
      checks++; if (irq_vec8 !== 8'h21 || irqout8 !== 1'b1) begin errors++; $display("FAIL multi_vec got=%h/%b exp=21/1", irq_vec8, irqout8); end
   endtask

   // ---------------------------------------------------------------------------
   initial begin
      rd = 0; wr = 0; addr = '0; wdata = '0;
      rd8 = 0; wr8 = 0; addr8 = '0; wdata8 = '0;
      reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      test_reset();
      test_periodic();
      test_prescaler();
      test_oneshot();
      test_collision();
      test_random();
      test_multi();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised, memory-mapped bank of NUM_CH independent reload timers with per-channel prescaler, one-shot/periodic mode and interrupt aggregation. It is the next-generation timer block of the Peripheral bus. It hangs on the CPU's data-memory side: rd/wr/addr/wdata/rdata, the same bus the CPU uses for LED, switch and digit-tube registers. Its irqout feeds the CPU IRQ input.

## Interface
- NUM_CH, 4, number of timer channels (1..8)
- TIMER_W, 32, counter/reload width (8..32); upper register bits read 0, writes ignored
- PRE_W, 16, prescaler width (1..16)
- BASE_ADDR, 32'h4000_0000, byte address of channel 0; must be 16-byte aligned

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted level 0 clears all state immediately
- rd  in  1  read strobe
- wr  in  1  write strobe, sampled on clk rising edge
- addr  in  32  byte address (ALU result); bits [1:0] ignored
- wdata  in  32  write data
- rdata  out  32  read data, combinational
- irqout  out  1  OR of all enabled pending channel interrupts, registered
- irq_vec  out  NUM_CH  per-channel pending & enabled, registered

## Operation
- Channel c occupies BASE_ADDR + 16*c:
  - +0 TH: reload value.
  - +4 TL: counter.
  - +8 TCON: [0] EN, [1] IE, [2] ST (status, write-1-to-clear), [3] OS (one-shot); other bits read 0.
  - +C PRE: prescale divisor.
- BASE_ADDR + 16*NUM_CH: IRQ_PEND, read-only, bit c = ST of channel c. Writes are ignored.
- Any other address: rdata = 0, writes ignored.
- Read: rdata = addressed register when rd=1 and the address hits; otherwise rdata = 0.
- Write: when wr=1 and the address hits, the register updates on the clk edge.
  - TCON write: EN, IE and OS take wdata bits; ST clears only if wdata[2]=1.
- Prescaler per channel: internal pcnt (PRE_W bits).
  - While EN=1: pcnt increments each cycle; when pcnt == PRE, a tick is issued and pcnt returns to 0.
  - PRE=0 gives a tick every cycle.
  - While EN=0: pcnt is held at 0.
- On tick:
  - TL != all-ones: TL <= TL+1.
  - TL == all-ones (overflow): TL <= TH, ST <= 1; if OS=1 then EN <= 0.
- Period in cycles = (PRE+1) * (2^TIMER_W - TH).
- Writing PRE or TL also clears pcnt to 0.
- irq_vec[c] <= ST[c] & IE[c]; irqout <= |(ST & IE).

## Timing
- Reset values: TH, TL, TCON, PRE, pcnt = 0; rdata = 0 (no rd); irqout = 0; irq_vec = 0.
- Register write is visible on rdata the cycle after the wr edge.
- Overflow tick at edge k: TL=TH and ST=1 readable after edge k; irq_vec/irqout go high after edge k+1 (one-cycle lag).
- Same-edge collisions:
  - Software write to TL vs hardware increment/reload: the software value wins, and ST is still set if an overflow tick occurred that edge.
  - Write-1-to-clear of ST vs overflow on the same edge: set wins, ST=1.
  - TCON write setting EN=1 vs one-shot auto-clear on the same edge: the software write wins, EN=1.
  - TH written on the overflow edge: the reload uses the old TH.
- Writing EN=0 freezes TL at its current value. Re-enabling resumes from that value with pcnt=0.
- Reset asserted mid-count returns all state to reset values asynchronously. Counting restarts only after software re-enables.
- Channels are fully independent; simultaneous overflows set their ST bits on the same edge.

## Test plan
- Reset and idle: pulse reset low with counters running → all registers read 0, irqout=0; unmapped address 0x4000_0FF0 reads 0, and a write to it leaves all registers unchanged.
- Periodic, ch0: TH=0xFFFF_FFFC, TL=0xFFFF_FFFC, PRE=0, TCON=0x3 → ST=1 after 4 ticks and TL=0xFFFF_FFFC; irqout rises one cycle later; write TCON=0x7 (W1C) → ST=0, irqout drops the next cycle; period repeats every 4 cycles.
- Prescaler, ch1: PRE=2, TH=TL=0xFFFF_FFFE, TCON=0x1 → TL increments every 3rd cycle; overflow after 6 cycles; ST=1, irqout stays 0 (IE=0).
- One-shot, ch2: TCON=0xB, TL=0xFFFF_FFFF → after one tick EN=0, ST=1, TL=TH and then held constant; IRQ_PEND=0x4.
- Collisions, ch3: issue a TL write and a W1C of ST on the overflow edge → TL = written value, ST=1.
- Multi-channel with NUM_CH=8, TIMER_W=16: ch0 and ch5 overflow on the same edge → IRQ_PEND=0x21, irq_vec=0x21 when IE=1; TL reads with upper 16 bits 0.
